image_layer_sched: RTL and testbench

- Layer sequencer for the 3x3 image convolution pipeline (padding, four2three, three2nine, conv_norm, quan, stride).
- Accepts a host command naming a contiguous run of layers, fetches each layer's 256-bit parameter word from a parameter RAM, and drives it onto the pipeline's REG_Para bus.
- Pulses the pipeline Start, waits for Stride_Complete, then advances to the next layer.
- Counts output beats and runs a stall watchdog so software can detect a hung layer.

---
 rtl/image_layer_sched.sv | 157 +++++++++++++++
 tb/tb_image_layer_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_layer_sched.sv
// Layer sequencer for the 3x3 convolution pipeline: fetches each layer's
// parameter word, starts the pipeline, and tracks beats and stalls per layer.
module image_layer_sched #(
  parameter int LAYER_W     = 6,
  parameter int PARA_ADDR_W = 6,
  parameter int BEAT_CNT_W  = 24,
  parameter int WDOG_W      = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Cmd_Valid,
  output logic                   Cmd_Ready,
  input  logic [LAYER_W-1:0]     Cmd_First_Layer,
  input  logic [LAYER_W-1:0]     Cmd_Layer_Num,
  input  logic [WDOG_W-1:0]      Wdog_Limit,
  output logic [PARA_ADDR_W-1:0] Para_Addr,
  output logic                   Para_Rd_En,
  input  logic [255:0]           Para_Data,
  output logic [255:0]           REG_Para,
  output logic                   Start,
  input  logic                   Stride_Complete,
  input  logic                   Beat_Valid,
  input  logic                   Beat_Ready,
  output logic                   Layer_Busy,
  output logic [LAYER_W-1:0]     Cur_Layer,
  output logic [BEAT_CNT_W-1:0]  Layer_Beats,
  output logic                   Done,
  output logic                   Err_Timeout,
  output logic [2:0]             dbg_state
);

  // Handshakes: a command transfers on a cycle where Cmd_Valid && Cmd_Ready;
  // an output beat transfers on a cycle where Beat_Valid && Beat_Ready.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_LOAD    = 3'd3,
    S_SETTLE  = 3'd4,
    S_START   = 3'd5,
    S_RUN     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [LAYER_W-1:0]      cur_layer_q, cur_layer_d;
  logic [LAYER_W-1:0]      rem_q, rem_d;
  logic [255:0]            reg_para_q, reg_para_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  logic [BEAT_CNT_W-1:0]   layer_beats_q, layer_beats_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    err_q, err_d;

  logic                    beat_fire;
  logic [BEAT_CNT_W-1:0]   beat_inc;
  logic [BEAT_CNT_W-1:0]   beat_total;
  logic [WDOG_W-1:0]       wdog_inc;
  logic                    wdog_hit;

  always_comb begin
    beat_fire  = Beat_Valid && Beat_Ready;
    beat_inc   = (beat_q == '1) ? beat_q : beat_q + BEAT_CNT_W'(1);
    beat_total = beat_fire ? beat_inc : beat_q;
    wdog_inc   = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
    // A beat in the current cycle restarts the stall window, so it never times out.
    wdog_hit   = (Wdog_Limit != '0) && !beat_fire && (wdog_inc >= Wdog_Limit);
  end

  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    rem_d         = rem_q;
    reg_para_d    = reg_para_q;
    beat_d        = beat_q;
    layer_beats_d = layer_beats_q;
    wdog_d        = wdog_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (Cmd_Valid) begin
          cur_layer_d = Cmd_First_Layer;
          rem_d       = (Cmd_Layer_Num == '0) ? '0 : Cmd_Layer_Num - LAYER_W'(1);
          err_d       = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH:   state_d = S_WAIT_RD;
      S_WAIT_RD: state_d = S_LOAD;
      S_LOAD: begin
        reg_para_d = Para_Data;
        state_d    = S_SETTLE;
      end
      S_SETTLE:  state_d = S_START;
      S_START: begin
        beat_d  = '0;
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        beat_d = beat_total;
        wdog_d = beat_fire ? '0 : wdog_inc;
        // Completion takes priority over a watchdog hit in the same cycle.
        if (Stride_Complete) begin
          layer_beats_d = beat_total;
          if (rem_q != '0) begin
            rem_d       = rem_q - LAYER_W'(1);
            cur_layer_d = cur_layer_q + LAYER_W'(1);
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_layer_q   <= '0;
      rem_q         <= '0;
      reg_para_q    <= '0;
      beat_q        <= '0;
      layer_beats_q <= '0;
      wdog_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      rem_q         <= rem_d;
      reg_para_q    <= reg_para_d;
      beat_q        <= beat_d;
      layer_beats_q <= layer_beats_d;
      wdog_q        <= wdog_d;
      err_q         <= err_d;
    end
  end

  // State-decoded strobes are masked by rst so nothing fires in a reset cycle.
  assign Cmd_Ready   = !rst && (state_q == S_IDLE);
  assign Para_Rd_En  = !rst && (state_q == S_FETCH);
  assign Start       = !rst && (state_q == S_START);
  assign Done        = !rst && (state_q == S_DONE);
  assign Layer_Busy  = !rst && ((state_q == S_START) || (state_q == S_RUN));
  assign Para_Addr   = PARA_ADDR_W'(cur_layer_q);
  assign Cur_Layer   = cur_layer_q;
  assign REG_Para    = reg_para_q;
  assign Layer_Beats = layer_beats_q;
  assign Err_Timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_image_layer_sched.sv
// Directed bench for image_layer_sched: parameter RAM model, address scoreboard,
// and hand-computed checks of latency, beat counts, watchdog and reset.
module tb_image_layer_sched;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           Cmd_Valid = 1'b0;
  logic           Cmd_Ready;
  logic [5:0]     Cmd_First_Layer = '0;
  logic [5:0]     Cmd_Layer_Num = '0;
  logic [19:0]    Wdog_Limit = '0;
  logic [5:0]     Para_Addr;
  logic           Para_Rd_En;
  logic [255:0]   Para_Data;
  logic [255:0]   REG_Para;
  logic           Start;
  logic           Stride_Complete = 1'b0;
  logic           Beat_Valid = 1'b0;
  logic           Beat_Ready = 1'b0;
  logic           Layer_Busy;
  logic [5:0]     Cur_Layer;
  logic [23:0]    Layer_Beats;
  logic           Done;
  logic           Err_Timeout;
  logic [2:0]     dbg_state;

  image_layer_sched dut (
    .clk(clk), .rst(rst),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_First_Layer(Cmd_First_Layer), .Cmd_Layer_Num(Cmd_Layer_Num),
    .Wdog_Limit(Wdog_Limit),
    .Para_Addr(Para_Addr), .Para_Rd_En(Para_Rd_En), .Para_Data(Para_Data),
    .REG_Para(REG_Para), .Start(Start), .Stride_Complete(Stride_Complete),
    .Beat_Valid(Beat_Valid), .Beat_Ready(Beat_Ready),
    .Layer_Busy(Layer_Busy), .Cur_Layer(Cur_Layer), .Layer_Beats(Layer_Beats),
    .Done(Done), .Err_Timeout(Err_Timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- parameter RAM, two-cycle read latency ----------------
  logic [255:0] ram [64];
  logic [255:0] rd_s1 = '0;
  logic [255:0] rd_s2 = '0;
  always @(posedge clk) begin
    if (Para_Rd_En) rd_s1 <= ram[Para_Addr];
    rd_s2 <= rd_s1;
  end
  assign Para_Data = rd_s2;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];
  int start_cnt = 0;
  int done_cnt  = 0;
  int reg_viol  = 0;
  logic [255:0] prev_reg = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (Start) start_cnt++;
    if (Done) done_cnt++;
    if (Layer_Busy && (REG_Para !== prev_reg)) reg_viol++;
    prev_reg = REG_Para;
    if (Para_Rd_En) begin
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("para_addr", Para_Addr, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the FETCH cycle right after the accept cycle.
  task automatic send_cmd(input logic [5:0] first, input logic [5:0] num, input logic [19:0] lim);
    int k = 0;
    while (!Cmd_Ready && k < 50) begin
      step();
      k++;
    end
    check("cmd_ready_wait", Cmd_Ready, 1);
    Cmd_Valid       = 1'b1;
    Cmd_First_Layer = first;
    Cmd_Layer_Num   = num;
    Wdog_Limit      = lim;
    step();
    Cmd_Valid       = 1'b0;
    Cmd_First_Layer = 6'($urandom_range(0, 63));
    Cmd_Layer_Num   = 6'($urandom_range(0, 63));
    check("fetch_rd_en", Para_Rd_En, 1);
  endtask

  // Called one cycle after the accept/completion; returns in the Start cycle.
  task automatic wait_start(input logic [5:0] layer, input int exp_lat);
    int k = 1;
    while (!Start && k < 16) begin
      step();
      k++;
    end
    check("start_latency", k, exp_lat);
    check("start_cur_layer", Cur_Layer, layer);
    check("start_reg_para", REG_Para, ram[layer]);
    check("start_busy", Layer_Busy, 1);
  endtask

  // Drives RUN cycles 1..ncyc; Stride_Complete on the last. Beat_Valid is high
  // up to last_valid, Beat_Ready on multiples of period; both forced on the last
  // cycle when beat_on_last. Returns in the cycle after completion.
  task automatic run_layer(input int ncyc, input int period, input int last_valid,
                           input bit beat_on_last);
    for (int i = 1; i <= ncyc; i++) begin
      step();
      Beat_Valid      = (i <= last_valid) || (beat_on_last && i == ncyc);
      Beat_Ready      = (period != 0 && (i % period) == 0) || (beat_on_last && i == ncyc);
      Stride_Complete = (i == ncyc);
    end
    step();
    Beat_Valid      = 1'b0;
    Beat_Ready      = 1'b0;
    Stride_Complete = 1'b0;
  endtask

  task automatic expect_done(input logic [23:0] beats);
    check("done_pulse", Done, 1);
    check("layer_beats", Layer_Beats, beats);
    check("busy_after_done", Layer_Busy, 0);
    step();
    check("done_one_cycle", Done, 0);
    check("ready_after_done", Cmd_Ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int d0;
    for (int i = 0; i < 64; i++) ram[i] = {8{32'h5000_0000 + 32'(i * 7)}};
    ram[3] = {32{8'hA5}};

    // reset
    repeat (3) step();
    check("rst_cmd_ready", Cmd_Ready, 0);
    check("rst_start", Start, 0);
    check("rst_reg_para", REG_Para, 0);
    check("rst_outs", {Para_Rd_En, Layer_Busy, Done, Err_Timeout, Cur_Layer, Layer_Beats, Para_Addr}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", Cmd_Ready, 1);

    // single layer 3, 40 accepted beats among stalled ones, done after 100 cycles
    exp_q.push_back(6'd3);
    send_cmd(6'd3, 6'd1, 20'd0);
    wait_start(6'd3, 5);
    run_layer(100, 2, 80, 1'b0);
    expect_done(24'd40);

    // three layers 0,1,2
    s0 = start_cnt; d0 = done_cnt;
    exp_q.push_back(6'd0); exp_q.push_back(6'd1); exp_q.push_back(6'd2);
    send_cmd(6'd0, 6'd3, 20'd0);
    wait_start(6'd0, 5);
    run_layer(20, 4, 20, 1'b0);
    check("mid_layer_beats", Layer_Beats, 24'd5);
    wait_start(6'd1, 5);
    run_layer(12, 3, 12, 1'b0);
    check("mid_layer_beats2", Layer_Beats, 24'd4);
    wait_start(6'd2, 5);
    run_layer(9, 0, 0, 1'b0);
    expect_done(24'd0);
    check("three_starts", start_cnt - s0, 3);
    check("one_done", done_cnt - d0, 1);

    // count 0 acts as 1
    s0 = start_cnt;
    exp_q.push_back(6'd5);
    send_cmd(6'd5, 6'd0, 20'd0);
    wait_start(6'd5, 5);
    run_layer(6, 1, 6, 1'b0);
    expect_done(24'd6);
    repeat (4) step();
    check("num0_one_start", start_cnt - s0, 1);

    // layer index wraps 63 -> 0
    exp_q.push_back(6'd63); exp_q.push_back(6'd0);
    send_cmd(6'd63, 6'd2, 20'd0);
    wait_start(6'd63, 5);
    run_layer(8, 0, 0, 1'b0);
    wait_start(6'd0, 5);
    run_layer(8, 2, 8, 1'b0);
    expect_done(24'd4);

    // watchdog trips after 50 stalled RUN cycles and abandons the rest
    s0 = start_cnt;
    exp_q.push_back(6'd7);
    send_cmd(6'd7, 6'd3, 20'd50);
    wait_start(6'd7, 5);
    for (int j = 1; j <= 50; j++) step();
    check("wdog_no_err_yet", Err_Timeout, 0);
    check("wdog_busy_c50", Layer_Busy, 1);
    step();
    check("wdog_err", Err_Timeout, 1);
    check("wdog_done", Done, 1);
    check("wdog_busy_off", Layer_Busy, 0);
    step();
    check("wdog_ready", Cmd_Ready, 1);
    check("wdog_err_sticky", Err_Timeout, 1);
    repeat (10) step();
    check("wdog_abandon", start_cnt - s0, 1);

    exp_q.push_back(6'd1);
    send_cmd(6'd1, 6'd1, 20'd0);
    check("err_cleared", Err_Timeout, 0);
    wait_start(6'd1, 5);
    run_layer(5, 0, 0, 1'b0);
    expect_done(24'd0);

    // beats every 40 cycles keep a 50-cycle watchdog quiet; last beat meets completion
    exp_q.push_back(6'd9);
    send_cmd(6'd9, 6'd1, 20'd50);
    wait_start(6'd9, 5);
    run_layer(520, 40, 520, 1'b1);
    check("beats_no_err", Err_Timeout, 0);
    expect_done(24'd13);

    // completion in the exact limit cycle wins over the watchdog
    exp_q.push_back(6'd12);
    send_cmd(6'd12, 6'd1, 20'd50);
    wait_start(6'd12, 5);
    run_layer(50, 0, 0, 1'b0);
    check("limit_tie_no_err", Err_Timeout, 0);
    expect_done(24'd0);

    // reset in RUN of layer 2 of 4
    exp_q.push_back(6'd10); exp_q.push_back(6'd11);
    send_cmd(6'd10, 6'd4, 20'd0);
    wait_start(6'd10, 5);
    run_layer(10, 0, 0, 1'b0);
    wait_start(6'd11, 5);
    for (int j = 1; j <= 5; j++) begin
      step();
      Beat_Valid = 1'b1;
      Beat_Ready = 1'b1;
    end
    rst = 1'b1;
    Beat_Valid = 1'b0;
    Beat_Ready = 1'b0;
    s0 = start_cnt; d0 = done_cnt;
    step();
    check("midrst_outs", {Cmd_Ready, Para_Rd_En, Start, Layer_Busy, Done, Err_Timeout,
                          Cur_Layer, Layer_Beats, Para_Addr}, 0);
    check("midrst_reg_para", REG_Para, 0);
    check("midrst_state", dbg_state, 0);
    rst = 1'b0;
    Stride_Complete = 1'b1;
    step();
    Stride_Complete = 1'b0;
    check("stray_ready", Cmd_Ready, 1);
    repeat (3) step();
    check("stray_no_start", start_cnt - s0, 0);
    check("stray_no_done", done_cnt - d0, 0);

    exp_q.push_back(6'd20);
    send_cmd(6'd20, 6'd1, 20'd0);
    wait_start(6'd20, 5);
    run_layer(7, 1, 7, 1'b0);
    expect_done(24'd7);

    repeat (3) step();
    check("addr_queue_empty", exp_q.size(), 0);
    check("reg_para_stable_busy", reg_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
